// File: rtl/fp_cmp_pkg.sv
// Shared constants and field helpers for the FloPoCo comparator.
// Operand layout: {exn[1:0], sign, exp[WE-1:0], frac[WF-1:0]}.
package fp_cmp_pkg;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  typedef enum logic [2:0] {
    OP_GE  = 3'b000,
    OP_GT  = 3'b001,
    OP_LE  = 3'b010,
    OP_LT  = 3'b011,
    OP_EQ  = 3'b100,
    OP_NE  = 3'b101,
    OP_MIN = 3'b110,
    OP_MAX = 3'b111
  } op_e;

  function automatic int fp_w(int we, int wf);
    return we + wf + 3;
  endfunction

  function automatic int sign_bit(int we, int wf);
    return we + wf;
  endfunction

  function automatic int exp_hi(int we, int wf);
    return we + wf - 1;
  endfunction

  function automatic int key_w(int we, int wf);
    return we + wf + 2;
  endfunction

endpackage

// File: rtl/fp_cmp_classify.sv
// Operand classification and unsigned magnitude-key ordering.
// Non-normal operands carry no exp/frac so all zeros/infs/NaNs collapse.
module fp_cmp_classify
  import fp_cmp_pkg::*;
#(
  parameter int WE = 11,
  parameter int WF = 19
) (
  input  logic [WE+WF+2:0] a,
  input  logic [WE+WF+2:0] b,
  output logic             lt_mag,
  output logic             eq_mag,
  output logic             nan_a,
  output logic             nan_b,
  output logic             zero_a,
  output logic             zero_b
);

  localparam int W  = fp_w(WE, WF);
  localparam int EH = exp_hi(WE, WF);
  localparam int KW = key_w(WE, WF);

  logic [1:0]    exn_a, exn_b;
  logic [EH:0]   mag_a, mag_b;
  logic [KW-1:0] key_a, key_b;

  assign exn_a = a[W-1:W-2];
  assign exn_b = b[W-1:W-2];

  assign mag_a = a[EH:0] & {(EH+1){exn_a == EXN_NORM}};
  assign mag_b = b[EH:0] & {(EH+1){exn_b == EXN_NORM}};

  assign key_a = {exn_a, mag_a};
  assign key_b = {exn_b, mag_b};

  assign lt_mag = key_a < key_b;
  assign eq_mag = key_a == key_b;
  assign nan_a  = exn_a == EXN_NAN;
  assign nan_b  = exn_b == EXN_NAN;
  assign zero_a = exn_a == EXN_ZERO;
  assign zero_b = exn_b == EXN_ZERO;

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage FloPoCo compare / min / max with tag sideband.
// One global enable stalls both stages while the output is held.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter int WE    = 11,
  parameter int WF    = 19,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF+2:0] inA,
  input  logic [WE+WF+2:0] inB,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic [WE+WF+2:0] res,
  output logic             unordered,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] nan_count
);

  localparam int W  = fp_w(WE, WF);
  localparam int SB = sign_bit(WE, WF);

  typedef struct packed {
    op_e              op;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             lt_mag;
    logic             eq_mag;
    logic             nan_a;
    logic             nan_b;
    logic             zero_a;
    logic             zero_b;
  } s1_t;

  s1_t  s1_d, s1_q;
  logic s1_valid;
  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign s1_d.op  = op_e'(op);
  assign s1_d.tag = in_tag;
  assign s1_d.a   = inA;
  assign s1_d.b   = inB;

  fp_cmp_classify #(.WE(WE), .WF(WF)) u_cls (
    .a      (inA),
    .b      (inB),
    .lt_mag (s1_d.lt_mag),
    .eq_mag (s1_d.eq_mag),
    .nan_a  (s1_d.nan_a),
    .nan_b  (s1_d.nan_b),
    .zero_a (s1_d.zero_a),
    .zero_b (s1_d.zero_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  logic         sa, sb, bz, diff, pos, neg;
  logic         lt, eq, gt, any_nan, flag_d;
  logic [W-1:0] min_v, max_v, res_d;

  assign sa      = s1_q.a[SB];
  assign sb      = s1_q.b[SB];
  assign bz      = s1_q.zero_a && s1_q.zero_b;
  assign diff    = !bz && (sa != sb);
  assign pos     = !bz && !sa && !sb;
  assign neg     = !bz && sa && sb;
  assign any_nan = s1_q.nan_a || s1_q.nan_b;
  assign gt      = !lt && !eq;

  always_comb begin
    lt = 1'b0;
    eq = 1'b0;
    unique case (1'b1)
      bz:   eq = 1'b1;
      diff: lt = sa;
      pos: begin
        lt = s1_q.lt_mag;
        eq = s1_q.eq_mag;
      end
      neg: begin
        lt = !s1_q.lt_mag && !s1_q.eq_mag;
        eq = s1_q.eq_mag;
      end
    endcase
  end

  // Zero pair: sign picks the winner; all other ties return inA.
  always_comb begin
    min_v = s1_q.a;
    max_v = s1_q.a;
    if (s1_q.nan_a && s1_q.nan_b) begin
      min_v = s1_q.a;
      max_v = s1_q.a;
    end else if (s1_q.nan_a) begin
      min_v = s1_q.b;
      max_v = s1_q.b;
    end else if (s1_q.nan_b) begin
      min_v = s1_q.a;
      max_v = s1_q.a;
    end else if (bz) begin
      min_v = (sb && !sa) ? s1_q.b : s1_q.a;
      max_v = (sa && !sb) ? s1_q.b : s1_q.a;
    end else if (lt) begin
      max_v = s1_q.b;
    end else if (gt) begin
      min_v = s1_q.b;
    end
  end

  always_comb begin
    flag_d = 1'b0;
    res_d  = '0;
    unique case (s1_q.op)
      OP_GE:  flag_d = !any_nan && !lt;
      OP_GT:  flag_d = !any_nan && gt;
      OP_LE:  flag_d = !any_nan && !gt;
      OP_LT:  flag_d = !any_nan && lt;
      OP_EQ:  flag_d = !any_nan && eq;
      OP_NE:  flag_d = any_nan || !eq;
      OP_MIN: res_d  = min_v;
      OP_MAX: res_d  = max_v;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      flag      <= 1'b0;
      res       <= '0;
      unordered <= 1'b0;
      out_tag   <= '0;
      nan_count <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        flag      <= flag_d;
        res       <= res_d;
        unordered <= any_nan;
        out_tag   <= s1_q.tag;
        if (any_nan && nan_count != '1)
          nan_count <= nan_count + CNT_W'(1);
      end
    end
  end

endmodule
